// File: rtl/decoder_rr_arbiter_8_if.sv
// Requester/decoder-side bundle of the shared 3:8 decoder arbiter.
// master = requesters driving req/done, slave = the arbiter producing the grant.
interface decoder_rr_arbiter_8_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic       en;
  logic [7:0] gnt;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  sel,
    input  en,
    input  gnt,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output sel,
    output en,
    output gnt,
    output timeout
  );
endinterface

// File: rtl/decoder_rr_arbiter_8.sv
// Round-robin owner of one 3:8 decoder shared by 8 requesters; grant held until
// done, request drop or MAX_HOLD cycles, with one idle cycle between grants.
//
// state | meaning
// IDLE  | no owner, scanning req from ptr for the next grant
// GRANT | sel owns the decoder, en/gnt asserted, hold_cnt counting
module decoder_rr_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  decoder_rr_arbiter_8_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;

  logic [2:0] pick_idx;
  logic       pick_vld;
  logic       rel_drop;
  logic       rel_to;

  // Scan from farthest to nearest so the entry closest to ptr wins.
  always_comb begin
    pick_idx = ptr;
    pick_vld = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (bus.req[ptr + 3'(k)]) begin
        pick_idx = ptr + 3'(k);
        pick_vld = 1'b1;
      end
    end
  end

  assign rel_drop = !bus.req[bus.sel];
  assign rel_to   = (MAX_HOLD != 0) && (hold_cnt == 8'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      hold_cnt    <= 8'd0;
      bus.sel     <= 3'd0;
      bus.en      <= 1'b0;
      bus.gnt     <= 8'h00;
      bus.timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.timeout <= 1'b0;
          if (pick_vld) begin
            bus.sel  <= pick_idx;
            bus.en   <= 1'b1;
            bus.gnt  <= 8'b1 << pick_idx;
            hold_cnt <= 8'd1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (bus.done || rel_drop || rel_to) begin
            bus.en      <= 1'b0;
            bus.gnt     <= 8'h00;
            ptr         <= bus.sel + 3'd1;
            state       <= IDLE;
            // A timeout coinciding with a normal release is not flagged.
            bus.timeout <= rel_to && !bus.done && !rel_drop;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_rr_arbiter_8.sv
// Directed bench for decoder_rr_arbiter_8 (MAX_HOLD=4): stimulus queues the
// expected post-edge outputs, an independent monitor pops and compares each cycle.
module tb_decoder_rr_arbiter_8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [12:0] exp_q[$];
  string       name_q[$];

  decoder_rr_arbiter_8_if bus ();

  decoder_rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs applied for the coming edge, plus the outputs required right after it.
  task automatic step(input logic r, input logic [7:0] rq, input logic d,
                      input logic e, input logic [2:0] s, input logic t,
                      input string nm);
    logic [7:0] g;
    @(negedge clk);
    rst      = r;
    bus.req  = rq;
    bus.done = d;
    g = e ? (8'd1 << s) : 8'd0;
    exp_q.push_back({e, s, g, t});
    name_q.push_back(nm);
  endtask

  always @(posedge clk) begin
    logic [12:0] exp_v;
    logic [12:0] act_v;
    string       nm;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {bus.en, bus.sel, bus.gnt, bus.timeout};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL %s: got en=%b sel=%0d gnt=%h timeout=%b, want en=%b sel=%0d gnt=%h timeout=%b",
                 nm, act_v[12], act_v[11:9], act_v[8:1], act_v[0],
                 exp_v[12], exp_v[11:9], exp_v[8:1], exp_v[0]);
      end
    end
  end

  initial begin
    bus.req  = 8'h00;
    bus.done = 1'b0;

    // 1: single requester, done in third grant cycle
    step(1, 8'h00, 0, 0, 3'd0, 0, "reset");
    step(0, 8'h01, 0, 1, 3'd0, 0, "t1_grant");
    step(0, 8'h01, 0, 1, 3'd0, 0, "t1_hold2");
    step(0, 8'h01, 0, 1, 3'd0, 0, "t1_hold3");
    step(0, 8'h01, 1, 0, 3'd0, 0, "t1_release");

    // 2: all requesting, done every grant cycle -> 0..7,0 with idle gaps
    step(1, 8'h00, 0, 0, 3'd0, 0, "t2_reset");
    for (int i = 0; i < 8; i++) begin
      step(0, 8'hFF, 1, 1, 3'(i), 0, "t2_grant");
      step(0, 8'hFF, 1, 0, 3'(i), 0, "t2_idle");
    end
    step(0, 8'hFF, 1, 1, 3'd0, 0, "t2_wrap_grant");
    step(0, 8'hFF, 1, 0, 3'd0, 0, "t2_wrap_idle");

    // 3: owner 6 released, then 7 and 0 wrap around
    step(0, 8'h40, 0, 1, 3'd6, 0, "t3_grant6");
    step(0, 8'h40, 1, 0, 3'd6, 0, "t3_rel6");
    step(0, 8'h81, 0, 1, 3'd7, 0, "t3_grant7");
    step(0, 8'h81, 1, 0, 3'd7, 0, "t3_rel7");
    step(0, 8'h81, 0, 1, 3'd0, 0, "t3_grant0");
    step(0, 8'h81, 1, 0, 3'd0, 0, "t3_rel0");
    step(0, 8'h00, 0, 0, 3'd0, 0, "t3_quiet");

    // 5: owner 3 drops its request in grant cycle 2; other bits ignored meanwhile
    step(0, 8'h08, 0, 1, 3'd3, 0, "t5_grant3");
    step(0, 8'h0F, 0, 1, 3'd3, 0, "t5_others_ignored");
    step(0, 8'h00, 0, 0, 3'd3, 0, "t5_drop");
    step(0, 8'hFF, 0, 1, 3'd4, 0, "t5_ptr_is_4");
    step(0, 8'hFF, 1, 0, 3'd4, 0, "t5_rel4");

    // 4: hold timeout after exactly 4 cycles, then regrant same owner
    step(0, 8'h10, 0, 1, 3'd4, 0, "t4_grant");
    step(0, 8'h10, 0, 1, 3'd4, 0, "t4_hold2");
    step(0, 8'h10, 0, 1, 3'd4, 0, "t4_hold3");
    step(0, 8'h10, 0, 1, 3'd4, 0, "t4_hold4");
    step(0, 8'h10, 0, 0, 3'd4, 1, "t4_timeout");
    step(0, 8'h10, 0, 1, 3'd4, 0, "t4_regrant");
    step(0, 8'h10, 0, 1, 3'd4, 0, "t4b_hold2");
    step(0, 8'h10, 0, 1, 3'd4, 0, "t4b_hold3");
    step(0, 8'h10, 0, 1, 3'd4, 0, "t4b_hold4");
    step(0, 8'h10, 1, 0, 3'd4, 0, "t4b_done_with_timeout");
    step(0, 8'h00, 1, 0, 3'd4, 0, "idle_done_ignored");

    // 6: reset in the middle of owner 5's grant
    step(0, 8'h20, 0, 1, 3'd5, 0, "t6_grant5");
    step(1, 8'h20, 0, 0, 3'd0, 0, "t6_reset_mid_grant");
    step(0, 8'hFF, 0, 1, 3'd0, 0, "t6_ptr_zero");
    step(0, 8'hFF, 1, 0, 3'd0, 0, "t6_rel0");
    step(0, 8'h00, 0, 0, 3'd0, 0, "t6_quiet");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending checks, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
